// File: rtl/alex_relay_tx.sv
// alex_relay_tx: packs LPF/HPF/antenna/PTT relay selections into a 16-bit frame,
// shifts it MSB-first to the Alex board and strobes spi_load to latch the relays.
// Optional feature macro: ALEX_REFRESH_EN (periodic retransmission every REFRESH_CYCLES).
module alex_relay_tx #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned GUARD   = 8
`ifdef ALEX_REFRESH_EN
    ,
    parameter int unsigned REFRESH_CYCLES = 1000000
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] lpf,
    input  logic [5:0] hpf,
    input  logic [1:0] ant,
    input  logic       ptt,
    output logic       spi_sdo,
    output logic       spi_sck,
    output logic       spi_load,
    output logic       busy,
    output logic       done
);
    localparam int unsigned FW = 16;
    localparam int unsigned CW = 8;
    localparam int unsigned BW = 4;
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(FW - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD, S_GUARD} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          half, half_n;
    logic [BW-1:0] bitc, bitc_n;
    logic [FW-1:0] sh, sh_n;
    logic [FW-1:0] cur;
    logic [FW-1:0] sent, sent_n;
    logic          force_set, force_n;
    logic          primed;
    logic          pending_c;
    logic          refresh_c;

`ifdef ALEX_REFRESH_EN
    localparam int unsigned RW = 32;
    logic [RW-1:0] rcnt;

    assign refresh_c = (rcnt == RW'(REFRESH_CYCLES - 1));

    // Free-running refresh timer, restarted by reset and by every frame start
    always_ff @(posedge clock) begin
        if (reset || (state == S_IDLE && state_n == S_SHIFT) || refresh_c) begin
            rcnt <= '0;
        end else begin
            rcnt <= rcnt + RW'(1);
        end
    end
`else
    assign refresh_c = 1'b0;
`endif

    // A frame is owed when forced (reset/refresh) or the live selection differs from the last one sent
    assign pending_c = force_set | refresh_c | (cur != sent);

    // Next-state, counter and shift-register logic
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        half_n  = half;
        bitc_n  = bitc;
        sh_n    = sh;
        sent_n  = sent;
        force_n = force_set | refresh_c;
        unique case (state)
            S_IDLE: begin
                cnt_n  = '0;
                half_n = 1'b0;
                bitc_n = '0;
                if (primed && pending_c) begin
                    state_n = S_SHIFT;
                    sh_n    = cur;
                    sent_n  = cur;
                    force_n = 1'b0;
                end
            end
            S_SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_n  = '0;
                    half_n = ~half;
                    if (half) begin
                        sh_n = {sh[FW-2:0], 1'b0};
                        if (bitc == BIT_LAST) begin
                            bitc_n  = '0;
                            state_n = S_LOAD;
                        end else begin
                            bitc_n = bitc + BW'(1);
                        end
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_LOAD: begin
                if (cnt == DIV_LAST) begin
                    cnt_n  = '0;
                    half_n = ~half;
                    if (half) begin
                        state_n = S_GUARD;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_GUARD: begin
                if (cnt == GUARD_LAST) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered link outputs (derived from next-state values)
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            half      <= 1'b0;
            bitc      <= '0;
            sh        <= '0;
            cur       <= '0;
            sent      <= '0;
            force_set <= 1'b1;
            primed    <= 1'b0;
            spi_sdo   <= 1'b0;
            spi_sck   <= 1'b0;
            spi_load  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            half      <= half_n;
            bitc      <= bitc_n;
            sh        <= sh_n;
            cur       <= {ptt, ant, hpf, lpf};
            sent      <= sent_n;
            force_set <= force_n;
            // cur holds its reset zero for one cycle; wait until it carries real inputs
            primed    <= 1'b1;
            spi_sdo   <= (state_n == S_SHIFT) && sh_n[FW-1];
            spi_sck   <= (state_n == S_SHIFT) && half_n;
            spi_load  <= (state_n == S_LOAD);
            busy      <= (state_n != S_IDLE);
            done      <= (state_n == S_GUARD) && (cnt_n == GUARD_LAST);
        end
    end
endmodule

// File: tb/tb_alex_relay_tx.sv
// Bench for alex_relay_tx: table of input vectors with hand-computed frame words,
// plus directed sequences for glitches, mid-frame changes, mid-frame reset and refresh.
module tb_alex_relay_tx;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] lpf   = 7'h01;
    logic [5:0] hpf   = 6'h00;
    logic [1:0] ant   = 2'd0;
    logic       ptt   = 1'b0;
    logic       spi_sdo, spi_sck, spi_load, busy, done;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

`ifdef ALEX_REFRESH_EN
    alex_relay_tx #(.CLK_DIV(4), .GUARD(8), .REFRESH_CYCLES(500)) dut (
        .clock(clock), .reset(reset), .lpf(lpf), .hpf(hpf), .ant(ant), .ptt(ptt),
        .spi_sdo(spi_sdo), .spi_sck(spi_sck), .spi_load(spi_load), .busy(busy), .done(done)
    );
`else
    alex_relay_tx #(.CLK_DIV(4), .GUARD(8)) dut (
        .clock(clock), .reset(reset), .lpf(lpf), .hpf(hpf), .ant(ant), .ptt(ptt),
        .spi_sdo(spi_sdo), .spi_sck(spi_sck), .spi_load(spi_load), .busy(busy), .done(done)
    );
`endif

    typedef struct {
        logic [6:0]  lpf;
        logic [5:0]  hpf;
        logic [1:0]  ant;
        logic        ptt;
        logic [15:0] word;
    } vec_t;

    typedef struct {
        int          seen;
        logic [15:0] word;
        int          nbits;
        int          start;
        int          load_first;
        int          load_len;
        int          done_off;
        int          overlap;
        int          busy_after;
    } frame_t;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for busy, then record one frame as the board would see it
    task automatic capture(input int max_wait, output frame_t f);
        logic prev_sck;
        int   n;
        f.seen = 0; f.word = '0; f.nbits = 0; f.start = -1; f.load_first = -1;
        f.load_len = 0; f.done_off = -1; f.overlap = 0; f.busy_after = 1;
        n = 0;
        while (!busy && n < max_wait) begin
            tick();
            n++;
        end
        if (!busy) return;
        f.seen   = 1;
        f.start  = cyc;
        prev_sck = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (spi_sck && !prev_sck) begin
                f.word = {f.word[14:0], spi_sdo};
                f.nbits++;
            end
            if (spi_load) begin
                if (f.load_first < 0) f.load_first = cyc - f.start;
                f.load_len++;
                if (spi_sck || spi_sdo) f.overlap = 1;
            end
            if (done) begin
                f.done_off = cyc - f.start;
                break;
            end
            prev_sck = spi_sck;
            tick();
        end
        tick();
        f.busy_after = int'(busy);
    endtask

    task automatic check_frame(input string tag, input frame_t f, input int ref_cyc,
                               input logic [15:0] w);
        check({tag, ".seen"},       f.seen, 1);
        check({tag, ".latency"},    f.start - ref_cyc, 2);
        check({tag, ".word"},       int'(f.word), int'(w));
        check({tag, ".nbits"},      f.nbits, 16);
        check({tag, ".load_first"}, f.load_first, 128);
        check({tag, ".load_len"},   f.load_len, 8);
        check({tag, ".done_off"},   f.done_off, 143);
        check({tag, ".overlap"},    f.overlap, 0);
        check({tag, ".busy_fall"},  f.busy_after, 0);
    endtask

    initial begin
        vec_t   vecs[4];
        frame_t f, f1, f2, f3;
        int     c0;
        int     n;
        int     load_seen;

        vecs[0] = '{lpf: 7'h20, hpf: 6'h00, ant: 2'd0, ptt: 1'b1, word: 16'h8020};
        vecs[1] = '{lpf: 7'h01, hpf: 6'h3F, ant: 2'd2, ptt: 1'b0, word: 16'h5F81};
        vecs[2] = '{lpf: 7'h40, hpf: 6'h15, ant: 2'd1, ptt: 1'b1, word: 16'hAAC0};
        vecs[3] = '{lpf: 7'h08, hpf: 6'h00, ant: 2'd3, ptt: 1'b0, word: 16'h6008};

        // Reset state
        repeat (3) tick();
        check("rst.sdo",  spi_sdo,  0);
        check("rst.sck",  spi_sck,  0);
        check("rst.load", spi_load, 0);
        check("rst.busy", busy,     0);
        check("rst.done", done,     0);

        // One frame after reset release, then silence
        reset = 1'b0;
        c0 = cyc;
        capture(50, f);
        check_frame("t1", f, c0, 16'h0001);
        capture(300, f);
        check("t1.no_extra", f.seen, 0);

        // Table-driven input changes while idle
        for (int i = 0; i < 4; i++) begin
            lpf = vecs[i].lpf; hpf = vecs[i].hpf; ant = vecs[i].ant; ptt = vecs[i].ptt;
            c0 = cyc;
            capture(50, f);
            check_frame($sformatf("vec%0d", i), f, c0, vecs[i].word);
            check($sformatf("vec%0d.idle_sdo", i),  spi_sdo,  0);
            check($sformatf("vec%0d.idle_sck", i),  spi_sck,  0);
            check($sformatf("vec%0d.idle_load", i), spi_load, 0);
        end

        // Sub-cycle glitch on hpf returns to the sent value: no frame
        hpf = 6'h3F;
        #2;
        hpf = 6'h00;
        capture(200, f);
        check("t3.no_frame", f.seen, 0);

        // Three ant changes during SHIFT merge into one following frame
        lpf = 7'h02; hpf = 6'h05; ant = 2'd0;
        c0 = cyc;
        fork
            capture(20, f1);
            begin
                repeat (10) tick();
                ant = 2'd1;
                repeat (5) tick();
                ant = 2'd2;
                repeat (5) tick();
                ant = 2'd3;
            end
        join
        check_frame("t4a", f1, c0, 16'h0282);
        capture(20, f2);
        check_frame("t4b", f2, f1.start + f1.done_off, 16'h6282);
        capture(300, f3);
        check("t4.no_third", f3.seen, 0);

        // Reset during SHIFT bit 7 aborts without a load strobe
        lpf = 7'h10;
        n = 0;
        while (!busy && n < 20) begin
            tick();
            n++;
        end
        check("t5.started", busy, 1);
        repeat (58) tick();
        reset = 1'b1;
        tick();
        check("t5.sdo",  spi_sdo,  0);
        check("t5.sck",  spi_sck,  0);
        check("t5.load", spi_load, 0);
        check("t5.busy", busy,     0);
        check("t5.done", done,     0);
        load_seen = 0;
        repeat (3) begin
            tick();
            if (spi_load) load_seen = 1;
        end
        check("t5.no_load", load_seen, 0);
        reset = 1'b0;
        c0 = cyc;
        capture(50, f);
        check_frame("t5", f, c0, 16'h6290);

        // Static inputs: periodic refresh only when the feature is built in
`ifdef ALEX_REFRESH_EN
        capture(600, f2);
        check("t6.seen1",   f2.seen, 1);
        check("t6.period1", f2.start - f.start, 500);
        check("t6.word1",   int'(f2.word), int'(16'h6290));
        capture(600, f3);
        check("t6.seen2",   f3.seen, 1);
        check("t6.period2", f3.start - f2.start, 500);
        check("t6.word2",   int'(f3.word), int'(16'h6290));
`else
        capture(5000, f2);
        check("t6.no_repeat", f2.seen, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
